// File: rtl/pm_ctrl_fsm_pkg.sv
// rtl/pm_ctrl_fsm_pkg.sv - shared types and constants for the picoMIPS controller
package pm_pkg;

   typedef enum logic [2:0] {
      NOP  = 3'd0,
      ADD  = 3'd1,
      MULI = 3'd2,
      LWD  = 3'd3,
      BEQ  = 3'd4,
      BNE  = 3'd5,
      BGE  = 3'd6,
      HLT  = 3'd7
   } opcode_e;

   typedef enum logic [1:0] {
      DECODE   = 2'd0,
      MUL_WAIT = 2'd1,
      IN_WAIT  = 2'd2,
      HALT     = 2'd3
   } state_e;

   localparam logic [2:0] RADD = 3'd1;
   localparam logic [2:0] RMUL = 3'd2;

   localparam int Z_BIT = 0;
   localparam int N_BIT = 1;

   // ALU function an instruction keeps driving for as long as it is in flight
   function automatic logic [2:0] alu_code(opcode_e op);
      return (op == MULI) ? RMUL : RADD;
   endfunction

endpackage

// File: rtl/pm_ctrl_fsm_if.sv
// rtl/pm_ctrl_fsm_if.sv - opcode/flag inputs and datapath control outputs of the controller
interface pm_ctrl_fsm_if #(
   parameter int OPC_W  = 3,
   parameter int NFLAGS = 2,
   parameter int ALUF_W = 3
);
   logic [OPC_W-1:0]  opcode;
   logic [NFLAGS-1:0] flags;
   logic              in_valid;
   logic              PCen;
   logic              PCincr;
   logic              PCrelbranch;
   logic [ALUF_W-1:0] ALUfunc;
   logic              imm;
   logic              w;
   logic              s_i;
   logic              dres;
   logic              busy;
   logic              halted;

   modport master (
      output opcode, flags, in_valid,
      input  PCen, PCincr, PCrelbranch, ALUfunc, imm, w, s_i, dres, busy, halted
   );

   modport slave (
      input  opcode, flags, in_valid,
      output PCen, PCincr, PCrelbranch, ALUfunc, imm, w, s_i, dres, busy, halted
   );
endinterface

// File: rtl/pm_ctrl_fsm.sv
// rtl/pm_ctrl_fsm.sv - sequential picoMIPS instruction controller with mul/load stalls and halt
import pm_pkg::*;

module pm_ctrl_fsm #(
   parameter int OPC_W   = 3,
   parameter int NFLAGS  = 2,
   parameter int ALUF_W  = 3,
   parameter int MUL_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   pm_ctrl_fsm_if.slave  bus
);

   localparam int CNT_W = $clog2(MUL_LAT) + 1;

   state_e            state, state_nxt;
   opcode_e           op_q, op_q_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   opcode_e           op;
   logic              illegal;
   logic              taken;

   assign op = opcode_e'(bus.opcode[2:0]);

   generate
      if (OPC_W > 3) begin : g_wide_opc
         assign illegal = |bus.opcode[OPC_W-1:3];
      end else begin : g_narrow_opc
         assign illegal = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DECODE;
         op_q  <= NOP;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         op_q  <= op_q_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      op_q_nxt        = op_q;
      cnt_nxt         = cnt;
      taken           = 1'b0;
      bus.PCen        = 1'b0;
      bus.PCincr      = 1'b0;
      bus.PCrelbranch = 1'b0;
      bus.ALUfunc     = '0;
      bus.imm         = 1'b0;
      bus.w           = 1'b0;
      bus.s_i         = 1'b0;
      bus.dres        = 1'b0;
      bus.busy        = 1'b0;
      bus.halted      = 1'b0;

      // reset blanks every output, including the PC and write strobes
      if (!reset) begin
         unique case (state)
            DECODE: begin
               if (illegal) begin
                  state_nxt = HALT;
               end else begin
                  case (op)
                     NOP: begin
                        bus.PCen   = 1'b1;
                        bus.PCincr = 1'b1;
                     end
                     ADD: begin
                        bus.ALUfunc = ALUF_W'(alu_code(op));
                        bus.w       = 1'b1;
                        bus.PCen    = 1'b1;
                        bus.PCincr  = 1'b1;
                     end
                     MULI: begin
                        bus.imm     = 1'b1;
                        bus.ALUfunc = ALUF_W'(alu_code(op));
                        if (MUL_LAT == 1) begin
                           bus.w      = 1'b1;
                           bus.PCen   = 1'b1;
                           bus.PCincr = 1'b1;
                        end else begin
                           bus.busy  = 1'b1;
                           cnt_nxt   = CNT_W'(MUL_LAT - 1);
                           op_q_nxt  = op;
                           state_nxt = MUL_WAIT;
                        end
                     end
                     LWD: begin
                        bus.imm     = 1'b1;
                        bus.dres    = 1'b1;
                        bus.ALUfunc = ALUF_W'(alu_code(op));
                        if (bus.in_valid) begin
                           bus.w      = 1'b1;
                           bus.PCen   = 1'b1;
                           bus.PCincr = 1'b1;
                        end else begin
                           bus.busy  = 1'b1;
                           op_q_nxt  = op;
                           state_nxt = IN_WAIT;
                        end
                     end
                     BEQ, BNE, BGE: begin
                        if (op == BEQ)      taken = bus.flags[Z_BIT];
                        else if (op == BNE) taken = !bus.flags[Z_BIT];
                        else                taken = !bus.flags[N_BIT];
                        bus.ALUfunc     = ALUF_W'(alu_code(op));
                        bus.s_i         = (op == BNE);
                        bus.PCen        = 1'b1;
                        bus.PCrelbranch = taken;
                        bus.PCincr      = !taken;
                     end
                     default: state_nxt = HALT;
                  endcase
               end
            end
            MUL_WAIT: begin
               bus.imm     = 1'b1;
               bus.ALUfunc = ALUF_W'(alu_code(op_q));
               cnt_nxt     = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bus.w      = 1'b1;
                  bus.PCen   = 1'b1;
                  bus.PCincr = 1'b1;
                  state_nxt  = DECODE;
               end else begin
                  bus.busy = 1'b1;
               end
            end
            IN_WAIT: begin
               bus.imm     = 1'b1;
               bus.dres    = 1'b1;
               bus.ALUfunc = ALUF_W'(alu_code(op_q));
               if (bus.in_valid) begin
                  bus.w      = 1'b1;
                  bus.PCen   = 1'b1;
                  bus.PCincr = 1'b1;
                  state_nxt  = DECODE;
               end else begin
                  bus.busy = 1'b1;
               end
            end
            HALT: bus.halted = 1'b1;
            default: state_nxt = DECODE;
         endcase
      end
   end

endmodule

// File: tb/tb_pm_ctrl_fsm.sv
// tb/tb_pm_ctrl_fsm.sv - randomized and directed checks of pm_ctrl_fsm at three multiply latencies
module tb_pm_ctrl_fsm;
   import pm_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] opc = 3'd0;
   logic [1:0] flg = 2'd0;
   logic       iv = 1'b0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   pm_ctrl_fsm_if bus1 ();
   pm_ctrl_fsm_if bus3 ();
   pm_ctrl_fsm_if bus4 ();

   assign bus1.opcode = opc;  assign bus1.flags = flg;  assign bus1.in_valid = iv;
   assign bus3.opcode = opc;  assign bus3.flags = flg;  assign bus3.in_valid = iv;
   assign bus4.opcode = opc;  assign bus4.flags = flg;  assign bus4.in_valid = iv;

   pm_ctrl_fsm #(.MUL_LAT(1)) u_lat1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   pm_ctrl_fsm #(.MUL_LAT(3)) u_lat3 (.clk(clk), .reset(reset), .bus(bus3.slave));
   pm_ctrl_fsm #(.MUL_LAT(4)) u_lat4 (.clk(clk), .reset(reset), .bus(bus4.slave));

   // {PCen, PCincr, PCrelbranch, ALUfunc[2:0], imm, w, s_i, dres, busy, halted}
   logic [11:0] obs [3];
   assign obs[0] = {bus1.PCen, bus1.PCincr, bus1.PCrelbranch, bus1.ALUfunc, bus1.imm,
                    bus1.w, bus1.s_i, bus1.dres, bus1.busy, bus1.halted};
   assign obs[1] = {bus3.PCen, bus3.PCincr, bus3.PCrelbranch, bus3.ALUfunc, bus3.imm,
                    bus3.w, bus3.s_i, bus3.dres, bus3.busy, bus3.halted};
   assign obs[2] = {bus4.PCen, bus4.PCincr, bus4.PCrelbranch, bus4.ALUfunc, bus4.imm,
                    bus4.w, bus4.s_i, bus4.dres, bus4.busy, bus4.halted};

   // reference: cycles elapsed in a multiply, pending load, halted flag
   int lat [3] = '{1, 3, 4};
   int mul_age [3] = '{0, 0, 0};
   bit load_pending [3] = '{0, 0, 0};
   bit hlt [3] = '{0, 0, 0};

   function automatic logic [11:0] expect_out(int k);
      logic pcen = 0, pcincr = 0, pcrel = 0, imm = 0, w = 0, si = 0, dres = 0, busy = 0, hl = 0;
      logic [2:0] alu = 3'd0;
      logic tk;
      if (reset) return 12'd0;
      if (hlt[k]) begin
         hl = 1;
      end else if (mul_age[k] > 0) begin
         imm = 1; alu = RMUL;
         if (mul_age[k] + 1 == lat[k]) begin w = 1; pcen = 1; pcincr = 1; end
         else busy = 1;
      end else if (load_pending[k]) begin
         imm = 1; dres = 1; alu = RADD;
         if (iv) begin w = 1; pcen = 1; pcincr = 1; end
         else busy = 1;
      end else begin
         case (opc)
            3'd0: begin pcen = 1; pcincr = 1; end
            3'd1: begin w = 1; alu = RADD; pcen = 1; pcincr = 1; end
            3'd2: begin
               imm = 1; alu = RMUL;
               if (lat[k] == 1) begin w = 1; pcen = 1; pcincr = 1; end
               else busy = 1;
            end
            3'd3: begin
               imm = 1; dres = 1; alu = RADD;
               if (iv) begin w = 1; pcen = 1; pcincr = 1; end
               else busy = 1;
            end
            3'd4, 3'd5, 3'd6: begin
               tk = (opc == 3'd4) ? flg[0] : (opc == 3'd5) ? !flg[0] : !flg[1];
               alu = RADD; pcen = 1; si = (opc == 3'd5);
               pcrel = tk; pcincr = !tk;
            end
            default: ;
         endcase
      end
      return {pcen, pcincr, pcrel, alu, imm, w, si, dres, busy, hl};
   endfunction

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            mul_age[k] = 0; load_pending[k] = 0; hlt[k] = 0;
         end else if (hlt[k]) begin
         end else if (mul_age[k] > 0) begin
            mul_age[k] = (mul_age[k] + 1 == lat[k]) ? 0 : mul_age[k] + 1;
         end else if (load_pending[k]) begin
            if (iv) load_pending[k] = 0;
         end else begin
            if (opc == 3'd2 && lat[k] > 1) mul_age[k] = 1;
            if (opc == 3'd3 && !iv) load_pending[k] = 1;
            if (opc == 3'd7) hlt[k] = 1;
         end
      end
   endtask

   task automatic check(input string tag);
      logic [11:0] exp_v;
      for (int k = 0; k < 3; k++) begin
         exp_v = expect_out(k);
         total++;
         assert (obs[k] === exp_v) else begin
            bad++;
            $error("FAIL %s[lat%0d] got=%h exp=%h", tag, lat[k], obs[k], exp_v);
         end
         total++;
         assert (((obs[k][10] & obs[k][9]) | (obs[k][4] & obs[k][1])) === 1'b0) else begin
            bad++;
            $error("FAIL %s_excl[lat%0d] got=%h exp=no PCincr&PCrelbranch, no w&busy", tag, lat[k], obs[k]);
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [2:0] op, input logic [1:0] f, input logic v,
                      input string tag);
      @(posedge clk);
      #1;
      reset = r; opc = op; flg = f; iv = v;
      #4;
      check(tag);
      model_step();
   endtask

   initial begin
      cyc(1, ADD, 2'b00, 0, "reset");
      cyc(1, ADD, 2'b00, 0, "reset");
      cyc(0, ADD, 2'b00, 0, "add");

      cyc(0, MULI, 2'b00, 0, "muli");
      cyc(0, MULI, 2'b00, 1, "muli");
      cyc(0, MULI, 2'b00, 1, "muli");
      cyc(0, MULI, 2'b00, 0, "muli");
      cyc(0, NOP,  2'b00, 0, "nop");

      for (int i = 0; i < 4; i++) cyc(0, LWD, 2'b00, 0, "lwd_wait");
      cyc(0, LWD, 2'b00, 1, "lwd_done");
      cyc(0, LWD, 2'b00, 1, "lwd_now");
      cyc(0, NOP, 2'b00, 0, "nop");

      cyc(0, BEQ, 2'b01, 0, "beq_z");
      cyc(0, BNE, 2'b01, 0, "bne_z");
      cyc(0, BGE, 2'b10, 0, "bge_n");
      cyc(0, BGE, 2'b00, 0, "bge_p");
      cyc(0, BEQ, 2'b00, 0, "beq_nz");
      cyc(0, BNE, 2'b00, 0, "bne_nz");

      cyc(0, MULI, 2'b00, 0, "muli_rst");
      cyc(1, MULI, 2'b00, 0, "muli_rst");
      cyc(0, NOP,  2'b00, 0, "post_rst");
      cyc(0, NOP,  2'b00, 0, "post_rst");

      for (int i = 0; i < 300; i++)
         cyc(($urandom_range(0, 39) == 0), 3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 2) != 0), "rand");

      cyc(0, HLT, 2'b00, 0, "hlt");
      for (int i = 0; i < 10; i++)
         cyc(0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "halted");
      cyc(1, NOP, 2'b00, 0, "hlt_rst");
      cyc(0, NOP, 2'b00, 0, "after_hlt");
      cyc(0, ADD, 2'b00, 0, "after_hlt");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
